// File: rtl/casr_state_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : casr_state_serializer
//  Purpose  : Snapshots the CASR state vector on request and streams it out
//             as a serial frame over a valid/ready bit interface:
//             start bit '1', WIDTH data bits MSB first, even-parity bit.
//             Also flags dropped captures (sticky overrun) and counts
//             completed frames (wrapping counter).
//  Ports    : clk        - clock
//             rst_n      - asynchronous active-low reset
//             i_state    - live CASR state vector
//             i_cap      - capture request (single-cycle pulse)
//             i_clr_ovr  - clear sticky overrun flag
//             i_ready    - downstream ready for o_bit
//             o_bit      - serial frame bit
//             o_valid    - o_bit valid
//             o_busy     - frame in progress
//             o_done     - one-cycle pulse after the parity beat is accepted
//             o_overrun  - sticky: a capture request was dropped
//             o_frames   - completed-frame count (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module casr_state_serializer #(
  parameter int WIDTH  = 37,
  parameter int CNT_W  = 6,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  i_state,
  input  logic              i_cap,
  input  logic              i_clr_ovr,
  input  logic              i_ready,
  output logic              o_bit,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overrun,
  output logic [FCNT_W-1:0] o_frames
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_START  = 2'd1;
  localparam logic [1:0] c_ST_DATA   = 2'd2;
  localparam logic [1:0] c_ST_PARITY = 2'd3;

  localparam logic [CNT_W-1:0]  c_CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
  localparam logic [FCNT_W-1:0] c_FCNT_ONE = FCNT_W'(1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic [FCNT_W-1:0] frames_q, frames_d;

  logic w_valid;
  logic w_bit;
  logic w_beat;
  logic w_last_beat;
  logic w_load;
  logic w_ovr_set;

  assign w_beat      = w_valid & i_ready;
  assign w_last_beat = (state_q == c_ST_PARITY) & w_beat;
  // A capture is taken from IDLE, or in the cycle the parity beat retires
  // (back-to-back frame with no gap cycle).
  assign w_load      = i_cap & ((state_q == c_ST_IDLE) | w_last_beat);
  // Any other capture while a frame is in flight is dropped.
  assign w_ovr_set   = i_cap & (state_q != c_ST_IDLE) & ~w_last_beat;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (i_cap) state_d = c_ST_START;
      end
      c_ST_START: begin
        if (w_beat) state_d = c_ST_DATA;
      end
      c_ST_DATA: begin
        if (w_beat && (cnt_q == '0)) state_d = c_ST_PARITY;
      end
      c_ST_PARITY: begin
        if (w_beat) state_d = i_cap ? c_ST_START : c_ST_IDLE;
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic (combinational from state and frame registers)
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid = 1'b0;
    w_bit   = 1'b0;
    case (state_q)
      c_ST_START: begin
        w_valid = 1'b1;
        w_bit   = 1'b1;
      end
      c_ST_DATA: begin
        w_valid = 1'b1;
        w_bit   = shadow_q[cnt_q];
      end
      c_ST_PARITY: begin
        w_valid = 1'b1;
        w_bit   = par_q;
      end
      default: begin
        w_valid = 1'b0;
        w_bit   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    frames_d = frames_q;
    done_d   = w_last_beat;
    // Set has priority over clear.
    ovr_d    = w_ovr_set | (ovr_q & ~i_clr_ovr);

    if ((state_q == c_ST_DATA) && w_beat) begin
      par_d = par_q ^ w_bit;
      if (cnt_q != '0) cnt_d = cnt_q - c_CNT_ONE;
    end

    if (w_last_beat) frames_d = frames_q + c_FCNT_ONE;

    if (w_load) begin
      shadow_d = i_state;
      cnt_d    = c_CNT_LOAD;
      par_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      frames_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      frames_q <= frames_d;
    end
  end

  assign o_bit     = w_bit;
  assign o_valid   = w_valid;
  assign o_busy    = (state_q != c_ST_IDLE);
  assign o_done    = done_q;
  assign o_overrun = ovr_q;
  assign o_frames  = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_casr_state_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_casr_state_serializer
//  Purpose  : Directed self-checking bench for casr_state_serializer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_casr_state_serializer;

  logic        clk;
  logic        rst_n;
  logic [36:0] i_state;
  logic        i_cap;
  logic        i_clr_ovr;
  logic        i_ready;
  logic        o_bit;
  logic        o_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;
  logic [7:0]  o_frames;

  int checks = 0;
  int errors = 0;

  casr_state_serializer #(
    .WIDTH (37),
    .CNT_W (6),
    .FCNT_W(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_state  (i_state),
    .i_cap    (i_cap),
    .i_clr_ovr(i_clr_ovr),
    .i_ready  (i_ready),
    .o_bit    (o_bit),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_overrun(o_overrun),
    .o_frames (o_frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Receive one frame starting in a cycle where the start bit is presented.
  // Optional per-beat events (-1 = none):
  //   cap_beat    : pulse i_cap (at beat 38 also present cap_data on i_state)
  //   capclr_beat : pulse i_cap together with i_clr_ovr
  //   chg_beat    : invert i_state (shadow must stay frozen)
  //   stop_beat   : abandon reception before this beat
  task automatic recv(input logic [36:0] data, input logic exp_par, input bit toggle,
                      input int cap_beat, input int capclr_beat, input int chg_beat,
                      input int stop_beat, input logic [36:0] cap_data,
                      input string tag, output int cycles);
    logic [38:0] seq;
    logic        held;
    bit          stalled;
    int          beat;
    seq     = {1'b1, data, exp_par};
    beat    = 0;
    cycles  = 0;
    stalled = 0;
    held    = 1'b0;
    while (beat < 39 && cycles < 200) begin
      if (beat == stop_beat) break;
      i_ready   = toggle ? ((cycles % 2) == 0) : 1'b1;
      i_cap     = 1'b0;
      i_clr_ovr = 1'b0;
      if (beat == cap_beat) begin
        i_cap = 1'b1;
        if (beat == 38) i_state = cap_data;
      end
      if (beat == capclr_beat) begin
        i_cap     = 1'b1;
        i_clr_ovr = 1'b1;
      end
      if (beat == chg_beat) i_state = ~i_state;
      if (stalled) chk({tag, "_stable"}, o_bit, held);
      chk({tag, "_valid"}, o_valid, 1'b1);
      if (i_ready) begin
        chk($sformatf("%s_bit%0d", tag, beat), o_bit, seq[38-beat]);
        beat++;
        stalled = 0;
      end else begin
        held    = o_bit;
        stalled = 1;
      end
      step();
      cycles++;
    end
    i_cap     = 1'b0;
    i_clr_ovr = 1'b0;
    i_ready   = 1'b1;
    if (stop_beat < 0) chk({tag, "_beats"}, beat, 39);
  endtask

  task automatic capture(input logic [36:0] d);
    i_state = d;
    i_cap   = 1'b1;
    step();
    i_cap   = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic [63:0] r;
    logic [36:0] d;

    rst_n     = 1'b0;
    i_state   = '0;
    i_cap     = 1'b0;
    i_clr_ovr = 1'b0;
    i_ready   = 1'b1;
    step();
    step();
    chk("rst_valid",   o_valid,   1'b0);
    chk("rst_bit",     o_bit,     1'b0);
    chk("rst_busy",    o_busy,    1'b0);
    chk("rst_done",    o_done,    1'b0);
    chk("rst_overrun", o_overrun, 1'b0);
    chk("rst_frames",  o_frames,  8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- 1) single frame, ready held high ----
    capture(37'h1_0000_0001);
    chk("t1_start_valid", o_valid, 1'b1);
    chk("t1_start_bit",   o_bit,   1'b1);
    chk("t1_busy",        o_busy,  1'b1);
    recv(37'h1_0000_0001, 1'b0, 0, -1, -1, -1, -1, '0, "t1", cyc);
    chk("t1_cycles", cyc, 39);
    chk("t1_done",   o_done,   1'b1);
    chk("t1_frames", o_frames, 8'd1);
    chk("t1_idle",   o_busy,   1'b0);
    step();
    chk("t1_done_pulse", o_done, 1'b0);

    // ---- 2) ready toggling ----
    capture(37'h0_0000_0007);
    recv(37'h0_0000_0007, 1'b1, 1, -1, -1, -1, -1, '0, "t2", cyc);
    chk("t2_cycles", cyc, 77);
    chk("t2_done",   o_done,   1'b1);
    chk("t2_frames", o_frames, 8'd2);

    // ---- 3) overrun, set-wins-over-clear, frozen shadow ----
    capture(37'h1_A5A5_A5A5);
    recv(37'h1_A5A5_A5A5, 1'b1, 0, 10, 20, 5, -1, '0, "t3", cyc);
    chk("t3_overrun", o_overrun, 1'b1);
    chk("t3_done",    o_done,    1'b1);
    chk("t3_frames",  o_frames,  8'd3);
    i_clr_ovr = 1'b1;
    step();
    i_clr_ovr = 1'b0;
    chk("t3_clr", o_overrun, 1'b0);
    chk("t3_no_restart", o_busy, 1'b0);

    // ---- 4) back-to-back capture on the parity beat ----
    capture(37'h0_FFFF_FFFF);
    recv(37'h0_FFFF_FFFF, 1'b0, 0, 38, -1, -1, -1, 37'h1_0000_0003, "t4a", cyc);
    chk("t4_done",    o_done,    1'b1);
    chk("t4_frames",  o_frames,  8'd4);
    chk("t4_valid",   o_valid,   1'b1);
    chk("t4_bit",     o_bit,     1'b1);
    chk("t4_busy",    o_busy,    1'b1);
    chk("t4_overrun", o_overrun, 1'b0);
    recv(37'h1_0000_0003, 1'b1, 0, -1, -1, -1, -1, '0, "t4b", cyc);
    chk("t4b_cycles", cyc, 39);
    chk("t4b_frames", o_frames, 8'd5);

    // ---- 5) asynchronous reset mid-frame ----
    capture(37'h0_1234_5678);
    recv(37'h0_1234_5678, 1'b1, 0, -1, -1, -1, 20, '0, "t5a", cyc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_valid",   o_valid,   1'b0);
    chk("t5_bit",     o_bit,     1'b0);
    chk("t5_busy",    o_busy,    1'b0);
    chk("t5_done",    o_done,    1'b0);
    chk("t5_overrun", o_overrun, 1'b0);
    chk("t5_frames",  o_frames,  8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    capture(37'h1_8000_0000);
    recv(37'h1_8000_0000, 1'b0, 0, -1, -1, -1, -1, '0, "t5b", cyc);
    chk("t5b_cycles", cyc, 39);
    chk("t5b_frames", o_frames, 8'd1);

    // ---- 6) 256 frames, counter wrap, random data ----
    rst_n = 1'b0;
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int f = 0; f < 256; f++) begin
      r = {$urandom(), $urandom()};
      d = r[36:0];
      capture(d);
      recv(d, ^d, 0, -1, -1, -1, -1, '0, "t6", cyc);
      if (f == 254) chk("t6_frames255", o_frames, 8'd255);
    end
    chk("t6_wrap",    o_frames,  8'd0);
    chk("t6_overrun", o_overrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
